// File: rtl/mux_arb_nx1_if.sv
// Bus bundle for mux_arb_nx1: producer side (valid/ready/data per channel),
// consumer side (y/valid/ready), mode/select controls and debug taps.
//
// Handshake: a word moves across a valid/ready pair on a rising clk edge
// exactly when both valid and ready are high in the cycle before that edge.
// Producers hold data and valid stable until their ready bit is seen.
// The block holds y_out/chan_out/valid_out stable while valid_out=1 and
// ready_in=0.
interface mux_arb_nx1_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode_in;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       ready_out;
  logic [WIDTH-1:0]          y_out;
  logic                      valid_out;
  logic [SEL_W-1:0]          chan_out;
  logic                      ready_in;

  // Debug taps: output stage FSM state (1 = FULL) and round-robin pointer.
  logic                      dbg_full;
  logic [SEL_W-1:0]          dbg_rr_ptr;

  // DUT side.
  modport slave (
    input  mode_in, sel_in, valid_in, data_in, ready_in,
    output ready_out, y_out, valid_out, chan_out, dbg_full, dbg_rr_ptr
  );

  // Environment side (producers + consumer).
  modport master (
    output mode_in, sel_in, valid_in, data_in, ready_in,
    input  ready_out, y_out, valid_out, chan_out, dbg_full, dbg_rr_ptr
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// N-channel, W-bit registered multiplexer/arbiter with a one-word output
// stage. Channel is chosen either by sel_in (select mode) or by a
// round-robin search starting at rr_ptr (round-robin mode).
module mux_arb_nx1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
) (
  input  logic           clk_in,
  input  logic           reset_in,
  mux_arb_nx1_if.slave   bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int PAD_N = 1 << SEL_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             gvalid;
  logic             xfer;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  int               rr_idx;

  // valid_in and data padded out to 2^SEL_W entries so any select value,
  // including ones >= CHANNELS, indexes a defined (zero) slot.
  logic [PAD_N-1:0] valid_ext;
  logic [WIDTH-1:0] data_arr [PAD_N];

  for (genvar gi = 0; gi < PAD_N; gi++) begin : g_pad
    if (gi < CHANNELS) begin : g_ch
      assign data_arr[gi] = bus.data_in[gi*WIDTH +: WIDTH];
    end else begin : g_zero
      assign data_arr[gi] = '0;
    end
  end

  // Zero-extend the valid vector to the padded width.
  always_comb begin
    valid_ext                 = '0;
    valid_ext[CHANNELS-1:0]   = bus.valid_in;
  end

  // Round-robin search: first valid channel at or after rr_ptr, wrapping
  // modulo CHANNELS. Scanning from the far end lets the nearest hit win.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= CHANNELS) rr_idx = rr_idx - CHANNELS;
      if (bus.valid_in[SEL_W'(rr_idx)]) begin
        rr_grant = SEL_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  // Grant selection by mode; an out-of-range sel_in lands on a zero pad bit.
  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    if (bus.mode_in) begin
      grant  = rr_grant;
      gvalid = rr_found;
    end else begin
      grant  = bus.sel_in;
      gvalid = valid_ext[bus.sel_in];
    end
  end

  assign load_en = (state_q == EMPTY) | bus.ready_in;
  assign xfer    = load_en & gvalid;

  // One-hot acceptance to the granted producer, suppressed during reset.
  always_comb begin
    bus.ready_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (xfer && !reset_in && (grant == SEL_W'(i))) bus.ready_out[i] = 1'b1;
    end
  end

  // Output stage next state: load on transfer, empty on load without data,
  // otherwise hold. rr_ptr moves past the winner only in round-robin mode.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en) begin
      if (gvalid) begin
        state_d = FULL;
        y_d     = data_arr[grant];
        chan_d  = grant;
        if (bus.mode_in) begin
          rr_ptr_d = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= EMPTY;
      y_q      <= '0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.y_out      = y_q;
  assign bus.valid_out  = (state_q == FULL);
  assign bus.chan_out   = chan_q;
  assign bus.dbg_full   = (state_q == FULL);
  assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: an 8-channel and a 6-channel instance, a
// behavioural model checked every cycle, plus directed literal checks.
module tb_mux_arb_nx1;
  logic clk = 1'b0;
  logic rst;

  // Clock/reset block.
  always #5 clk = ~clk;

  mux_arb_nx1_if #(.WIDTH(16), .CHANNELS(8)) b8 ();
  mux_arb_nx1_if #(.WIDTH(16), .CHANNELS(6)) b6 ();

  mux_arb_nx1 #(.WIDTH(16), .CHANNELS(8)) u8 (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (b8.slave)
  );

  mux_arb_nx1 #(.WIDTH(16), .CHANNELS(6)) u6 (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (b6.slave)
  );

  typedef struct packed {
    logic        full;
    logic [15:0] y;
    int          chan;
    int          rr;
  } model_t;

  model_t      m8, m6;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model of one cycle: returns the state after the coming edge and the
  // ready vector that must be visible now.
  function automatic model_t model_step(input model_t m, input int n, input bit r,
                                        input bit mode, input int sel, input logic [7:0] v,
                                        input logic [127:0] d, input bit rdy,
                                        output logic [7:0] rexp);
    model_t nm;
    int     g;
    bit     load;
    nm   = m;
    g    = -1;
    rexp = '0;
    if (r) begin
      nm = '0;
      return nm;
    end
    load = !m.full || rdy;
    if (!mode) begin
      if (sel < n && v[sel]) g = sel;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (g < 0 && v[(m.rr + k) % n]) g = (m.rr + k) % n;
      end
    end
    if (load && g >= 0) begin
      rexp[g] = 1'b1;
      nm.full = 1'b1;
      nm.y    = d[g*16 +: 16];
      nm.chan = g;
      if (mode) nm.rr = (g + 1) % n;
    end else if (load) begin
      nm.full = 1'b0;
    end
    return nm;
  endfunction

  // Scoreboard: compare both instances against the model every cycle.
  initial begin : compare
    logic [7:0] r8, r6;
    m8 = '0;
    m6 = '0;
    @(negedge clk);
    forever begin
      chk("u8 valid_out", 32'(b8.valid_out), 32'(m8.full));
      chk("u8 dbg_full",  32'(b8.dbg_full),  32'(m8.full));
      chk("u8 y_out",     32'(b8.y_out),     32'(m8.y));
      chk("u8 chan_out",  32'(b8.chan_out),  m8.chan);
      chk("u8 rr_ptr",    32'(b8.dbg_rr_ptr), m8.rr);
      m8 = model_step(m8, 8, rst, b8.mode_in, int'(b8.sel_in), b8.valid_in,
                      b8.data_in, b8.ready_in, r8);
      chk("u8 ready_out", 32'(b8.ready_out), 32'(r8));

      chk("u6 valid_out", 32'(b6.valid_out), 32'(m6.full));
      chk("u6 y_out",     32'(b6.y_out),     32'(m6.y));
      chk("u6 chan_out",  32'(b6.chan_out),  m6.chan);
      chk("u6 rr_ptr",    32'(b6.dbg_rr_ptr), m6.rr);
      m6 = model_step(m6, 6, rst, b6.mode_in, int'(b6.sel_in), {2'b00, b6.valid_in},
                      {32'h0, b6.data_in}, b6.ready_in, r6);
      chk("u6 ready_out", 32'(b6.ready_out), 32'(r6));
      @(negedge clk);
    end
  end

  // Time limit so the run always ends.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Driver with directed vectors and hand-computed literal expectations.
  initial begin : driver
    logic [15:0] e;
    rst          = 1'b1;
    b8.mode_in   = 1'b0;
    b8.sel_in    = '0;
    b8.valid_in  = 8'hFF;
    b8.ready_in  = 1'b1;
    for (int i = 0; i < 8; i++) b8.data_in[i*16 +: 16] = 16'h1000 + 16'(i);
    b6.mode_in   = 1'b0;
    b6.sel_in    = '0;
    b6.valid_in  = 6'h3F;
    b6.ready_in  = 1'b1;
    for (int i = 0; i < 6; i++) b6.data_in[i*16 +: 16] = 16'h2000 + 16'(i);

    // Reset held two cycles with all channels valid.
    neg();
    chk("rst ready8", 32'(b8.ready_out), 32'h0);
    chk("rst valid8", 32'(b8.valid_out), 32'h0);
    chk("rst y8",     32'(b8.y_out),     32'h0);
    chk("rst chan8",  32'(b8.chan_out),  32'h0);
    chk("rst ready6", 32'(b6.ready_out), 32'h0);
    cyc();
    neg();
    chk("rst2 ready8", 32'(b8.ready_out), 32'h0);
    chk("rst2 valid8", 32'(b8.valid_out), 32'h0);
    cyc();
    rst         = 1'b0;
    b8.valid_in = '0;
    b6.valid_in = '0;
    neg();
    chk("post-rst valid8", 32'(b8.valid_out), 32'h0);
    chk("post-rst y8",     32'(b8.y_out),     32'h0);
    chk("post-rst chan8",  32'(b8.chan_out),  32'h0);

    // Select mode, channel 5.
    cyc();
    b8.sel_in    = 3'd5;
    b8.valid_in  = 8'b0010_0000;
    b8.data_in[5*16 +: 16] = 16'hBEEF;
    neg();
    chk("sel ready", 32'(b8.ready_out), 32'h20);
    cyc();
    b8.valid_in  = '0;
    neg();
    chk("sel y",     32'(b8.y_out),     32'hBEEF);
    chk("sel valid", 32'(b8.valid_out), 32'h1);
    chk("sel chan",  32'(b8.chan_out),  32'h5);

    // Backpressure: hold 1234 for three cycles while ch2 waits.
    cyc();
    b8.sel_in    = 3'd3;
    b8.valid_in  = 8'b0000_1000;
    b8.data_in[3*16 +: 16] = 16'h1234;
    neg();
    chk("bp load ready", 32'(b8.ready_out), 32'h08);
    cyc();
    b8.ready_in  = 1'b0;
    b8.sel_in    = 3'd2;
    b8.valid_in  = 8'b0000_0100;
    b8.data_in[2*16 +: 16] = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("bp hold y",     32'(b8.y_out),     32'h1234);
      chk("bp hold ready", 32'(b8.ready_out), 32'h0);
      chk("bp hold valid", 32'(b8.valid_out), 32'h1);
      if (i < 2) cyc();
    end
    cyc();
    b8.ready_in  = 1'b1;
    neg();
    chk("bp release ready", 32'(b8.ready_out), 32'h04);
    chk("bp release y",     32'(b8.y_out),     32'h1234);
    cyc();
    b8.valid_in  = '0;
    neg();
    chk("bp refill y",     32'(b8.y_out),     32'h5678);
    chk("bp refill chan",  32'(b8.chan_out),  32'h2);
    chk("bp refill valid", 32'(b8.valid_out), 32'h1);

    // Round-robin fairness: all valid, data = channel index.
    cyc();
    b8.mode_in   = 1'b1;
    b8.valid_in  = 8'hFF;
    for (int i = 0; i < 8; i++) b8.data_in[i*16 +: 16] = 16'(i);
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(i % 8));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) b8.valid_in = '0;
      neg();
      e = exp_q.pop_front();
      chk("rr fair chan", 32'(b8.chan_out), 32'(e));
      chk("rr fair y",    32'(b8.y_out),    32'(e));
    end
    cyc();
    neg();
    chk("rr fair drain", 32'(b8.valid_out), 32'h0);

    // Round-robin skip and wrap from reset: channels 1 and 7.
    cyc();
    rst          = 1'b1;
    cyc();
    rst          = 1'b0;
    b8.valid_in  = 8'b1000_0010;
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd7);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd7);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) b8.valid_in = '0;
      neg();
      e = exp_q.pop_front();
      chk("rr wrap chan", 32'(b8.chan_out), 32'(e));
    end
    cyc();
    neg();
    chk("rr wrap drain", 32'(b8.valid_out), 32'h0);

    // Six-channel instance: out-of-range select, then mid-operation reset.
    cyc();
    b6.sel_in    = 3'd4;
    b6.valid_in  = 6'b01_0000;
    b6.data_in[4*16 +: 16] = 16'hABCD;
    neg();
    chk("u6 sel4 ready", 32'(b6.ready_out), 32'h10);
    cyc();
    b6.sel_in    = 3'd7;
    b6.valid_in  = 6'h3F;
    neg();
    chk("u6 sel7 ready", 32'(b6.ready_out), 32'h0);
    chk("u6 sel7 valid", 32'(b6.valid_out), 32'h1);
    chk("u6 sel7 y",     32'(b6.y_out),     32'hABCD);
    cyc();
    neg();
    chk("u6 sel7 empty", 32'(b6.valid_out), 32'h0);
    chk("u6 sel7 yhold", 32'(b6.y_out),     32'hABCD);
    chk("u6 sel7 chold", 32'(b6.chan_out),  32'h4);
    cyc();
    b6.sel_in    = 3'd2;
    b6.valid_in  = 6'b00_0100;
    b6.data_in[2*16 +: 16] = 16'h5A5A;
    neg();
    chk("u6 sel2 ready", 32'(b6.ready_out), 32'h04);
    cyc();
    b6.ready_in  = 1'b0;
    b6.valid_in  = '0;
    neg();
    chk("u6 full y",     32'(b6.y_out),     32'h5A5A);
    chk("u6 full valid", 32'(b6.valid_out), 32'h1);
    cyc();
    rst          = 1'b1;
    b6.mode_in   = 1'b1;
    b6.valid_in  = 6'h3F;
    b6.ready_in  = 1'b1;
    neg();
    chk("u6 in-rst ready", 32'(b6.ready_out), 32'h0);
    cyc();
    rst          = 1'b0;
    neg();
    chk("u6 after-rst valid", 32'(b6.valid_out),  32'h0);
    chk("u6 after-rst rr",    32'(b6.dbg_rr_ptr), 32'h0);
    chk("u6 after-rst ready", 32'(b6.ready_out),  32'h01);
    cyc();
    b6.valid_in  = '0;
    neg();
    chk("u6 rr0 chan", 32'(b6.chan_out),  32'h0);
    chk("u6 rr0 y",    32'(b6.y_out),     32'h2000);
    chk("u6 rr0 valid", 32'(b6.valid_out), 32'h1);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
